// File: rtl/hv_adc_pkg.sv
// Shared definitions for the HV ADC threshold monitor.
// Holds the FSM state codes, the default data and debounce widths, and a
// threshold bundle used when the monitor is hooked up to a register bank.
package hv_adc_pkg;

  localparam int unsigned ADC_DW_DEF = 10;
  localparam int unsigned DEB_DW_DEF = 4;

  // Codes are read back by firmware, so they are fixed explicitly.
  typedef enum logic [2:0] {
    ST_NORM   = 3'd0,
    ST_OV_DEB = 3'd1,
    ST_UV_DEB = 3'd2,
    ST_OV_FLT = 3'd3,
    ST_UV_FLT = 3'd4
  } mon_state_e;

  // Threshold group as seen by the register bank.
  typedef struct packed {
    logic [ADC_DW_DEF-1:0] ov_th;
    logic [ADC_DW_DEF-1:0] ov_rls_th;
    logic [ADC_DW_DEF-1:0] uv_th;
    logic [ADC_DW_DEF-1:0] uv_rls_th;
  } thr_cfg_t;

endpackage

// File: rtl/hv_adc_thr_cmp.sv
// Combinational threshold comparator for one ADC channel.
// Ports:
//   data        averaged ADC sample (unsigned)
//   ov_th       OV trip threshold       -> ov_hit_c : data >  ov_th
//   ov_rls_th   OV release threshold    -> ov_rls_c : data <= ov_rls_th
//   uv_th       UV trip threshold       -> uv_hit_c : data <  uv_th
//   uv_rls_th   UV release threshold    -> uv_rls_c : data >= uv_rls_th
module hv_adc_thr_cmp #(
  parameter int unsigned ADC_DW = 10
) (
  input  logic [ADC_DW-1:0] data,
  input  logic [ADC_DW-1:0] ov_th,
  input  logic [ADC_DW-1:0] ov_rls_th,
  input  logic [ADC_DW-1:0] uv_th,
  input  logic [ADC_DW-1:0] uv_rls_th,
  output logic              ov_hit_c,
  output logic              uv_hit_c,
  output logic              ov_rls_c,
  output logic              uv_rls_c
);

  assign ov_hit_c = (data >  ov_th);
  assign uv_hit_c = (data <  uv_th);
  assign ov_rls_c = (data <= ov_rls_th);
  assign uv_rls_c = (data >= uv_rls_th);

endmodule

// File: rtl/hv_adc_thr_mon.sv
// HV ADC over/under-voltage threshold monitor, one instance per channel.
// Debounces OV/UV hits over consecutive valid samples, raises a fault flag
// and a one-cycle interrupt on fault entry, and releases with hysteresis.
// Build option: HV_ADC_THR_MON_LATCH_EN
//   defined   - faults latch until i_flt_clr, honoured only once the most
//               recent sample meets the release threshold
//   undefined - faults auto-release after deb_eff consecutive release
//               samples; i_flt_clr is ignored
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_adc_vld/_data     new averaged sample strobe and value
//   i_mon_en            monitor enable; low forces NORM
//   i_ov_th/_rls_th     OV trip / release thresholds
//   i_uv_th/_rls_th     UV trip / release thresholds
//   i_deb_num           consecutive samples to trip/release (0 acts as 1)
//   i_flt_clr           fault clear request (latched build only)
//   o_ov_flt/o_uv_flt   fault flags
//   o_flt_irq           one-cycle pulse on any fault entry
//   o_state             current FSM state code
module hv_adc_thr_mon
  import hv_adc_pkg::*;
#(
  parameter int unsigned ADC_DW = ADC_DW_DEF,
  parameter int unsigned DEB_DW = DEB_DW_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_adc_vld,
  input  logic [ADC_DW-1:0] i_adc_data,
  input  logic              i_mon_en,
  input  logic [ADC_DW-1:0] i_ov_th,
  input  logic [ADC_DW-1:0] i_ov_rls_th,
  input  logic [ADC_DW-1:0] i_uv_th,
  input  logic [ADC_DW-1:0] i_uv_rls_th,
  input  logic [DEB_DW-1:0] i_deb_num,
  input  logic              i_flt_clr,
  output logic              o_ov_flt,
  output logic              o_uv_flt,
  output logic              o_flt_irq,
  output logic [2:0]        o_state
);

  localparam logic [DEB_DW-1:0] CNT_MAX = '1;

  mon_state_e        state, state_nxt;
  logic [DEB_DW-1:0] cnt, cnt_nxt, cnt_inc, deb_eff;
  logic              ov_hit, uv_hit, ov_rls, uv_rls, flt_rls;
  logic              in_flt, in_flt_nxt, flt_rise;
  logic              ov_flt_q, uv_flt_q, irq_q;

  hv_adc_thr_cmp #(.ADC_DW(ADC_DW)) u_cmp (
    .data      (i_adc_data),
    .ov_th     (i_ov_th),
    .ov_rls_th (i_ov_rls_th),
    .uv_th     (i_uv_th),
    .uv_rls_th (i_uv_rls_th),
    .ov_hit_c  (ov_hit),
    .uv_hit_c  (uv_hit),
    .ov_rls_c  (ov_rls),
    .uv_rls_c  (uv_rls)
  );

  assign deb_eff    = (i_deb_num == '0) ? DEB_DW'(1) : i_deb_num;
  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + DEB_DW'(1);
  assign flt_rls    = (state == ST_OV_FLT) ? ov_rls : uv_rls;
  assign in_flt     = (state == ST_OV_FLT) || (state == ST_UV_FLT);
  assign in_flt_nxt = (state_nxt == ST_OV_FLT) || (state_nxt == ST_UV_FLT);
  assign flt_rise   = in_flt_nxt && !in_flt;

`ifdef HV_ADC_THR_MON_LATCH_EN
  logic rls_ok, rls_ok_nxt;
`else
  logic unused_flt_clr;
  assign unused_flt_clr = i_flt_clr;
`endif

  // Next-state / counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef HV_ADC_THR_MON_LATCH_EN
    rls_ok_nxt = rls_ok;
`endif
    if (!i_mon_en) begin
      state_nxt = ST_NORM;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_NORM: begin
          // OV wins when misconfigured thresholds make both hit
          if (i_adc_vld && (ov_hit || uv_hit)) begin
            if (deb_eff == DEB_DW'(1)) begin
              state_nxt = ov_hit ? ST_OV_FLT : ST_UV_FLT;
              cnt_nxt   = '0;
            end else begin
              state_nxt = ov_hit ? ST_OV_DEB : ST_UV_DEB;
              cnt_nxt   = DEB_DW'(1);
            end
          end
        end
        ST_OV_DEB, ST_UV_DEB: begin
          if (i_adc_vld) begin
            if ((state == ST_OV_DEB) ? ov_hit : uv_hit) begin
              // >= keeps a deb_num lowered mid-debounce from stalling the trip
              if (cnt_inc >= deb_eff) begin
                state_nxt = (state == ST_OV_DEB) ? ST_OV_FLT : ST_UV_FLT;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = cnt_inc;
              end
            end else begin
              state_nxt = ST_NORM;
              cnt_nxt   = '0;
            end
          end
        end
        ST_OV_FLT, ST_UV_FLT: begin
`ifdef HV_ADC_THR_MON_LATCH_EN
          // A sample arriving with the clear decides the release
          if (i_adc_vld) rls_ok_nxt = flt_rls;
          if (i_flt_clr && (i_adc_vld ? flt_rls : rls_ok)) begin
            state_nxt = ST_NORM;
            cnt_nxt   = '0;
          end
`else
          if (i_adc_vld) begin
            if (flt_rls) begin
              if (cnt_inc >= deb_eff) begin
                state_nxt = ST_NORM;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = cnt_inc;
              end
            end else begin
              cnt_nxt = '0;
            end
          end
`endif
        end
        default: begin
          state_nxt = ST_NORM;
          cnt_nxt   = '0;
        end
      endcase
    end
`ifdef HV_ADC_THR_MON_LATCH_EN
    // Release evidence never carries over into a new fault episode
    if (!in_flt_nxt) rls_ok_nxt = 1'b0;
`endif
  end

  // State, counter and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_NORM;
      cnt      <= '0;
      ov_flt_q <= 1'b0;
      uv_flt_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ov_flt_q <= (state_nxt == ST_OV_FLT);
      uv_flt_q <= (state_nxt == ST_UV_FLT);
      irq_q    <= flt_rise;
    end
  end

`ifdef HV_ADC_THR_MON_LATCH_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rls_ok <= 1'b0;
    else          rls_ok <= rls_ok_nxt;
  end
`endif

  assign o_ov_flt  = ov_flt_q;
  assign o_uv_flt  = uv_flt_q;
  assign o_flt_irq = irq_q;
  assign o_state   = state;

endmodule

// File: tb/tb_hv_adc_thr_mon.sv
// Self-checking bench for hv_adc_thr_mon: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
// Follows the HV_ADC_THR_MON_LATCH_EN build option of the design.
module tb_hv_adc_thr_mon;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       adc_vld = 1'b0;
  logic [9:0] adc_data = '0;
  logic       mon_en = 1'b0;
  logic [9:0] ov_th = 10'd800, ov_rls_th = 10'd750;
  logic [9:0] uv_th = 10'd100, uv_rls_th = 10'd120;
  logic [3:0] deb_num = 4'd3;
  logic       flt_clr = 1'b0;
  logic       ov_flt, uv_flt, flt_irq;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  hv_adc_thr_mon #(.ADC_DW(10), .DEB_DW(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_adc_vld   (adc_vld),
    .i_adc_data  (adc_data),
    .i_mon_en    (mon_en),
    .i_ov_th     (ov_th),
    .i_ov_rls_th (ov_rls_th),
    .i_uv_th     (uv_th),
    .i_uv_rls_th (uv_rls_th),
    .i_deb_num   (deb_num),
    .i_flt_clr   (flt_clr),
    .o_ov_flt    (ov_flt),
    .o_uv_flt    (uv_flt),
    .o_flt_irq   (flt_irq),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic eov, input logic euv,
                            input logic eirq, input int est);
    chk({name, ".ov_flt"},  32'(ov_flt),  32'(eov));
    chk({name, ".uv_flt"},  32'(uv_flt),  32'(euv));
    chk({name, ".flt_irq"}, 32'(flt_irq), 32'(eirq));
    chk({name, ".state"},   32'(state),   32'(est));
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge.
  task automatic drive(input logic vld, input int data, input logic en,
                       input logic clr, input int deb);
    adc_vld  = vld;
    adc_data = 10'(data);
    mon_en   = en;
    flt_clr  = clr;
    deb_num  = 4'(deb);
    @(posedge clk);
    #1;
    adc_vld = 1'b0;
    flt_clr = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       vld;
    logic [9:0] data;
    logic       en;
    logic [3:0] deb;
    logic       ov;
    logic       uv;
    logic       irq;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic vld, input int data, input logic en, input int deb,
                     input logic ov, input logic uv, input logic irq, input int st);
    vec_t v;
    v.vld = vld; v.data = 10'(data); v.en = en; v.deb = 4'(deb);
    v.ov = ov; v.uv = uv; v.irq = irq; v.st = 3'(st);
    vecs.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  // Fault episode view: either idle/counting a run of qualifying samples of
  // one kind, or faulted and counting release evidence.
  bit m_flt;
  int m_kind;   // 1 = over-voltage, 2 = under-voltage
  int m_run;
`ifdef HV_ADC_THR_MON_LATCH_EN
  bit m_rls_ok;
`endif

  task automatic model_step();
    int d;
    bit ovh, uvh, rel;
    d   = (deb_num == 0) ? 1 : int'(deb_num);
    ovh = adc_data > ov_th;
    uvh = adc_data < uv_th;
    if (!mon_en) begin
      m_flt = 0;
      m_run = 0;
    end else if (!m_flt) begin
      if (adc_vld) begin
        if (m_run == 0) begin
          if (ovh)      begin m_kind = 1; m_run = 1; end
          else if (uvh) begin m_kind = 2; m_run = 1; end
        end else if ((m_kind == 1) ? ovh : uvh) begin
          m_run++;
        end else begin
          m_run = 0;
        end
        if (m_run > 0 && m_run >= d) begin
          m_flt = 1;
          m_run = 0;
`ifdef HV_ADC_THR_MON_LATCH_EN
          m_rls_ok = 0;
`endif
        end
      end
    end else begin
      rel = (m_kind == 1) ? (adc_data <= ov_rls_th) : (adc_data >= uv_rls_th);
`ifdef HV_ADC_THR_MON_LATCH_EN
      if (adc_vld) m_rls_ok = rel;
      if (flt_clr && m_rls_ok) begin m_flt = 0; m_run = 0; end
`else
      if (adc_vld) begin
        if (rel) begin
          m_run++;
          if (m_run >= d) begin m_flt = 0; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end
`endif
    end
  endtask

  function automatic int model_code();
    if (m_flt)      return (m_kind == 1) ? 3 : 4;
    if (m_run == 0) return 0;
    return (m_kind == 1) ? 1 : 2;
  endfunction

  task automatic run_random(input int n);
    int  sel, base;
    bit  prev_flt;
    for (int i = 0; i < n; i++) begin
      adc_vld = ($urandom_range(0, 9) < 6);
      sel = int'($urandom_range(0, 6));
      case (sel)
        0: base = int'(ov_th)     + int'($urandom_range(0, 2)) - 1;
        1: base = int'(ov_rls_th) + int'($urandom_range(0, 2)) - 1;
        2: base = int'(uv_th)     + int'($urandom_range(0, 2)) - 1;
        3: base = int'(uv_rls_th) + int'($urandom_range(0, 2)) - 1;
        4: base = int'(ov_th)     + int'($urandom_range(1, 100));
        5: base = int'(uv_th)     - int'($urandom_range(1, 40));
        default: base = int'($urandom_range(0, 1023));
      endcase
      adc_data = 10'(base);
      mon_en   = ($urandom_range(0, 99) >= 3);
      flt_clr  = ($urandom_range(0, 9) == 0);
      prev_flt = m_flt;
      model_step();
      @(posedge clk);
      #1;
      check_outs($sformatf("rnd%0d", i), m_flt && (m_kind == 1), m_flt && (m_kind == 2),
                 m_flt && !prev_flt, model_code());
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    check_outs("post_reset", 0, 0, 0, 0);

    // vld, data, en, deb, ov, uv, irq, state
    add(1, 801, 1, 3, 0, 0, 0, 1);   // debounce trip
    add(1, 802, 1, 3, 0, 0, 0, 1);
    add(1, 805, 1, 3, 1, 0, 1, 3);
    add(0, 805, 1, 3, 1, 0, 0, 3);
    add(0,   0, 0, 3, 0, 0, 0, 0);
    add(1, 801, 1, 3, 0, 0, 0, 1);   // debounce break
    add(0, 801, 1, 3, 0, 0, 0, 1);
    add(1, 802, 1, 3, 0, 0, 0, 1);
    add(1, 700, 1, 3, 0, 0, 0, 0);
    add(1, 801, 1, 3, 0, 0, 0, 1);
    add(0,   0, 0, 3, 0, 0, 0, 0);
    add(1, 100, 1, 0, 0, 0, 0, 0);   // UV with deb_num 0
    add(1,  99, 1, 0, 0, 1, 1, 4);
    add(0,  99, 1, 0, 0, 1, 0, 4);
    add(0,   0, 0, 0, 0, 0, 0, 0);
    add(1, 900, 1, 4, 0, 0, 0, 1);   // disable mid-debounce
    add(1, 900, 1, 4, 0, 0, 0, 1);
    add(1, 900, 0, 4, 0, 0, 0, 0);
    add(1, 900, 1, 4, 0, 0, 0, 1);
    add(1, 900, 1, 4, 0, 0, 0, 1);
    add(1, 900, 1, 4, 0, 0, 0, 1);
    add(1, 900, 1, 4, 1, 0, 1, 3);
    add(0,   0, 0, 4, 0, 0, 0, 0);
    add(1, 801, 1, 2, 0, 0, 0, 1);   // UV hit does not jump OV_DEB -> UV_DEB
    add(1,  50, 1, 2, 0, 0, 0, 0);
    add(1,  50, 1, 2, 0, 0, 0, 2);
    add(1,  50, 1, 2, 0, 1, 1, 4);
    add(0,   0, 0, 2, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].vld, int'(vecs[i].data), vecs[i].en, 1'b0, int'(vecs[i].deb));
      check_outs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].uv, vecs[i].irq, int'(vecs[i].st));
    end

    // misconfigured thresholds: both hit, OV wins
    ov_th = 10'd100; ov_rls_th = 10'd90; uv_th = 10'd200; uv_rls_th = 10'd210;
    drive(1, 150, 1, 0, 1);
    check_outs("both_hit", 1, 0, 1, 3);
    drive(0, 0, 0, 0, 1);
    check_outs("both_hit_off", 0, 0, 0, 0);
    ov_th = 10'd800; ov_rls_th = 10'd750; uv_th = 10'd100; uv_rls_th = 10'd120;

`ifdef HV_ADC_THR_MON_LATCH_EN
    drive(1,  99, 1, 0, 0); check_outs("lat_trip",  0, 1, 1, 4);
    drive(1, 110, 1, 0, 0); check_outs("lat_s110",  0, 1, 0, 4);
    drive(0,   0, 1, 1, 0); check_outs("lat_clr_x", 0, 1, 0, 4);
    drive(1, 130, 1, 0, 0); check_outs("lat_s130",  0, 1, 0, 4);
    drive(0,   0, 1, 1, 0); check_outs("lat_clr_ok", 0, 0, 0, 0);
    drive(1,  99, 1, 0, 0); check_outs("lat_trip2", 0, 1, 1, 4);
    drive(1, 110, 1, 0, 0); check_outs("lat_s110b", 0, 1, 0, 4);
    drive(1, 125, 1, 1, 0); check_outs("lat_clr_vld", 0, 0, 0, 0);
`else
    drive(1, 801, 1, 0, 2); check_outs("rls_d1",  0, 0, 0, 1);
    drive(1, 801, 1, 0, 2); check_outs("rls_trip", 1, 0, 1, 3);
    drive(0,   0, 1, 1, 2); check_outs("rls_clr_ign", 1, 0, 0, 3);
    drive(1, 760, 1, 0, 2); check_outs("rls_s760", 1, 0, 0, 3);
    drive(1, 740, 1, 0, 2); check_outs("rls_s740", 1, 0, 0, 3);
    drive(1, 745, 1, 0, 2); check_outs("rls_s745", 0, 0, 0, 0);
`endif

    // asynchronous reset while faulted
    drive(1, 801, 1, 0, 1);
    check_outs("ar_trip", 1, 0, 1, 3);
    #2 rst_n = 1'b0;
    #1 check_outs("ar_async", 0, 0, 0, 0);
    @(posedge clk);
    #1 check_outs("ar_held", 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 1);
    check_outs("ar_after", 0, 0, 0, 0);

    // randomized run against the model, fresh from reset
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    m_flt = 0; m_kind = 1; m_run = 0;
`ifdef HV_ADC_THR_MON_LATCH_EN
    m_rls_ok = 0;
`endif
    for (int b = 0; b < 3; b++) begin
      ov_th     = 10'($urandom_range(600, 900));
      ov_rls_th = ov_th - 10'($urandom_range(0, 100));
      uv_th     = 10'($urandom_range(50, 300));
      uv_rls_th = uv_th + 10'($urandom_range(0, 100));
      deb_num   = 4'($urandom_range(0, 3));
      run_random(400);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
